pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage AArch64 pipeline. Generates en/clr for the
//  IF/ID, ID/EX, EX/MEM and MEM/WR pipeline registers and the PC enable/redirect select.
//  Resolves I-cache wait, D-cache wait, multi-cycle EX ops, load-use hazards, branch redirects
//  and full flushes. Tracks redirects and flushes raised while a cache access is outstanding.
// PARAMETERS
//  CNT_W    32   width of stall performance counter
//  HANG_LIM 1024 consecutive D-wait cycles before hang_err sets (>=2)
// PORTS
//  clk          in  1     core clock
//  rst          in  1     synchronous, active-high reset
//  i_busy       in  1     I-cache fetch outstanding this cycle
//  d_busy       in  1     D-cache access in MEM outstanding this cycle
//  ex_busy      in  1     multi-cycle op (mul/div) in EX not finished
//  load_use     in  1     ID instr needs result of a load currently in EX
//  br_taken     in  1     EX resolved redirect (qualified by EX valid)
//  flush_req    in  1     flush-all request (exception/eret/sync), 1-cycle pulse
//  pc_en        out 1     PC register update enable
//  pc_redir     out 1     PC takes redirect target this cycle
//  en_fd,clr_fd out 1,1   IF/ID enable / clear
//  en_de,clr_de out 1,1   ID/EX enable / clear
//  en_em,clr_em out 1,1   EX/MEM enable / clear
//  en_mw,clr_mw out 1,1   MEM/WR enable / clear
//  stall_cnt    out CNT_W cycles with pc_en==0 (saturating)
//  hang_err     out 1     sticky: d_busy held HANG_LIM cycles
// BEHAVIOUR
//  - Register contract: en=0 holds stage (MEM/WR drops valid); clr effective only with en=1.
//  - Outputs combinational from inputs + state; zero-latency. Reset: state=RUN, pending flags 0,
//    stall_cnt=0, hang_err=0. Outputs while rst=1: all en=1, all clr=1, pc_en=0, pc_redir=0.
//  - States: RUN, FLUSH_WAIT, KILL_FETCH. Priority in RUN (highest first):
//    1 d_busy: all en=0, pc_en=0.
//    2 ex_busy: pc_en=0, en_fd=en_de=0; en_em=1,clr_em=1 (bubble); en_mw=1.
//    3 br_taken: pc_en=1,pc_redir=1; en_fd=clr_fd=1, en_de=clr_de=1; EX/MEM,MEM/WR advance.
//      If i_busy same cycle -> KILL_FETCH.
//    4 load_use: pc_en=0, en_fd=0; en_de=clr_de=1; later stages advance.
//    5 i_busy: pc_en=0; en_fd=clr_fd=1 (bubble); later stages advance.
//    6 none: all en=1, clr=0, pc_en=1.
//  - flush_req: if d_busy=0 -> all en=1,all clr=1, pc_en=1, pc_redir=1 this cycle
//    (overrides 2-5; if i_busy too -> KILL_FETCH, else RUN); if d_busy=1 -> FLUSH_WAIT.
//  - FLUSH_WAIT: all en=0 while d_busy; first cycle d_busy=0 perform flush as above, leave.
//    Further flush_req/br_taken ignored while in FLUSH_WAIT.
//  - KILL_FETCH: stale fetch outstanding. IF/ID forced en=1,clr=1, pc_en=0 while i_busy;
//    cycle i_busy falls: clr_fd=1 still (discard return), pc_en=1, -> RUN. Later stages follow
//    RUN priorities 1,2 (d_busy/ex_busy); a new br_taken in KILL_FETCH re-redirects, stays.
//  - Simultaneous d_busy+br_taken: d_busy wins; br_taken must be held by EX (EX frozen).
//  - stall_cnt += 1 each cycle pc_en==0 and rst==0; saturates at all-ones, no wrap.
//  - hang counter counts consecutive d_busy cycles, clears when d_busy=0; reaching HANG_LIM
//    sets hang_err, cleared only by rst. Reset mid-stall returns to RUN next cycle.
// STRUCTURE
//  - Package pipes: typedef enum logic[1:0] hz_state_t {RUN,FLUSH_WAIT,KILL_FETCH};
//    typedef struct packed {en,clr} stage_ctrl_t; typedef stage_ctrl_t [3:0] pipe_ctrl_t.
//  - Package common: stage indices FD=0,DE=1,EM=2,MW=3.
//  - One sub-module: sat_counter (parameterised width, inc, clr, saturate) used for stall_cnt
//    and hang counter. FSM + priority decode stay in this module.
// TESTING
//  1 Load-use: load_use=1 one cycle -> pc_en=0,en_fd=0,en_de=1,clr_de=1; next cycle all en=1.
//  2 D-miss 3 cycles: d_busy=1 x3 -> all en=0 x3, stall_cnt=3; 4th cycle all en=1.
//  3 Redirect during I-miss: br_taken=1,i_busy=1 -> pc_redir=1,clr_fd=clr_de=1, KILL_FETCH;
//    i_busy 2 more cycles then 0 -> clr_fd=1 on fall cycle, next cycle RUN, clr_fd=0.
//  4 Flush under D-miss: flush_req with d_busy=1 for 4 cycles -> FLUSH_WAIT, en=0 x4;
//    5th cycle all clr=1, pc_redir=1; br_taken during wait produces no pc_redir.
//  5 EX busy 5 cycles: ex_busy=1 -> en_em=clr_em=1, en_de=0 each cycle; load_use masked.
//  6 Hang: HANG_LIM=8, d_busy=1 x8 -> hang_err=1 at 8th cycle, stays 1 after d_busy=0;
//    rst=1 one cycle -> hang_err=0, stall_cnt=0, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and stage indices for the pipeline hazard sequencer
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        KILL_FETCH = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic en;
        logic clr;
    } stage_ctrl_t;

    typedef stage_ctrl_t [3:0] pipe_ctrl_t;

    localparam int FD = 0;
    localparam int DE = 1;
    localparam int EM = 2;
    localparam int MW = 3;

    function automatic stage_ctrl_t sc(input logic en, input logic clr);
        stage_ctrl_t s;
        s.en  = en;
        s.clr = clr;
        return s;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer driving pipeline register enables and PC control
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int HANG_LIM = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_busy,
    input  logic             d_busy,
    input  logic             ex_busy,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             flush_req,
    output logic             pc_en,
    output logic             pc_redir,
    output logic             en_fd,
    output logic             clr_fd,
    output logic             en_de,
    output logic             clr_de,
    output logic             en_em,
    output logic             clr_em,
    output logic             en_mw,
    output logic             clr_mw,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             hang_err
);

    localparam int HW = $clog2(HANG_LIM + 1);

    hz_state_t  state, next_state;
    pipe_ctrl_t ctrl;
    logic       pc_en_c, pc_redir_c;
    logic [HW-1:0] hang_cnt;
    logic       hang_q, hang_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pc_en_c    = 1'b1;
        pc_redir_c = 1'b0;
        for (int i = 0; i < 4; i++) ctrl[i] = sc(1'b1, 1'b0);

        case (state)
            RUN, KILL_FETCH: begin
                // A stale fetch is still in flight: keep discarding IF/ID until it lands
                if (state == KILL_FETCH) begin
                    ctrl[FD] = sc(1'b1, 1'b1);
                    pc_en_c  = !i_busy;
                    if (!i_busy) next_state = RUN;
                end
                if (flush_req && !d_busy) begin
                    for (int i = 0; i < 4; i++) ctrl[i] = sc(1'b1, 1'b1);
                    pc_en_c    = 1'b1;
                    pc_redir_c = 1'b1;
                    next_state = i_busy ? KILL_FETCH : RUN;
                end else if (flush_req || d_busy) begin
                    for (int i = 0; i < 4; i++) begin
                        if (state == RUN || i != FD) ctrl[i] = sc(1'b0, 1'b0);
                    end
                    pc_en_c = 1'b0;
                    if (flush_req) next_state = FLUSH_WAIT;
                end else if (ex_busy) begin
                    pc_en_c  = 1'b0;
                    if (state == RUN) ctrl[FD] = sc(1'b0, 1'b0);
                    ctrl[DE] = sc(1'b0, 1'b0);
                    ctrl[EM] = sc(1'b1, 1'b1);
                end else if (br_taken) begin
                    pc_en_c    = 1'b1;
                    pc_redir_c = 1'b1;
                    ctrl[FD]   = sc(1'b1, 1'b1);
                    ctrl[DE]   = sc(1'b1, 1'b1);
                    next_state = i_busy ? KILL_FETCH : RUN;
                end else if (state == RUN && load_use) begin
                    pc_en_c  = 1'b0;
                    ctrl[FD] = sc(1'b0, 1'b0);
                    ctrl[DE] = sc(1'b1, 1'b1);
                end else if (state == RUN && i_busy) begin
                    pc_en_c  = 1'b0;
                    ctrl[FD] = sc(1'b1, 1'b1);
                end
            end
            FLUSH_WAIT: begin
                if (d_busy) begin
                    for (int i = 0; i < 4; i++) ctrl[i] = sc(1'b0, 1'b0);
                    pc_en_c = 1'b0;
                end else begin
                    for (int i = 0; i < 4; i++) ctrl[i] = sc(1'b1, 1'b1);
                    pc_redir_c = 1'b1;
                    next_state = i_busy ? KILL_FETCH : RUN;
                end
            end
            default: next_state = RUN;
        endcase

        if (rst) begin
            for (int i = 0; i < 4; i++) ctrl[i] = sc(1'b1, 1'b1);
            pc_en_c    = 1'b0;
            pc_redir_c = 1'b0;
        end
    end

    assign pc_en    = pc_en_c;
    assign pc_redir = pc_redir_c;
    assign en_fd    = ctrl[FD].en;
    assign clr_fd   = ctrl[FD].clr;
    assign en_de    = ctrl[DE].en;
    assign clr_de   = ctrl[DE].clr;
    assign en_em    = ctrl[EM].en;
    assign clr_em   = ctrl[EM].clr;
    assign en_mw    = ctrl[MW].en;
    assign clr_mw   = ctrl[MW].clr;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (!pc_en_c),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(HW)) u_hang_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!d_busy),
        .inc (d_busy),
        .cnt (hang_cnt)
    );

    // Flag in the same cycle the limit is reached, then hold it until reset
    assign hang_hit = !rst && d_busy && (hang_cnt >= HW'(HANG_LIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hang_q <= 1'b0;
        end else if (hang_hit) begin
            hang_q <= 1'b1;
        end
    end

    assign hang_err = hang_q || hang_hit;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int HANG_LIM = 8;

    localparam logic [9:0] P_RUN   = 10'b1010101010;
    localparam logic [9:0] P_RST   = 10'b0011111111;
    localparam logic [9:0] P_LU    = 10'b0000111010;
    localparam logic [9:0] P_FRZ   = 10'b0000000000;
    localparam logic [9:0] P_BR    = 10'b1111111010;
    localparam logic [9:0] P_KILL  = 10'b0011101010;
    localparam logic [9:0] P_KFALL = 10'b1011101010;
    localparam logic [9:0] P_FLUSH = 10'b1111111111;
    localparam logic [9:0] P_EX    = 10'b0000001110;

    logic clk = 1'b0;
    logic rst, i_busy, d_busy, ex_busy, load_use, br_taken, flush_req;
    logic pc_en, pc_redir, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw;
    logic [CNT_W-1:0] stall_cnt;
    logic hang_err;
    logic [9:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .HANG_LIM(HANG_LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_busy    (i_busy),
        .d_busy    (d_busy),
        .ex_busy   (ex_busy),
        .load_use  (load_use),
        .br_taken  (br_taken),
        .flush_req (flush_req),
        .pc_en     (pc_en),
        .pc_redir  (pc_redir),
        .en_fd     (en_fd),
        .clr_fd    (clr_fd),
        .en_de     (en_de),
        .clr_de    (clr_de),
        .en_em     (en_em),
        .clr_em    (clr_em),
        .en_mw     (en_mw),
        .clr_mw    (clr_mw),
        .stall_cnt (stall_cnt),
        .hang_err  (hang_err)
    );

    assign ctl = {pc_en, pc_redir, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
    task automatic drive(input logic r, input logic ib, input logic db, input logic eb,
                         input logic lu, input logic bt, input logic fr);
        rst = r; i_busy = ib; d_busy = db; ex_busy = eb;
        load_use = lu; br_taken = bt; flush_req = fr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst_ctl", 32'(ctl), 32'(P_RST));
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("idle_ctl", 32'(ctl), 32'(P_RUN));
        check("idle_stall", 32'(stall_cnt), 32'd0);
        check("idle_hang", 32'(hang_err), 32'd0);
        tick();

        drive(0, 0, 0, 0, 1, 0, 0);
        check("lu_ctl", 32'(ctl), 32'(P_LU));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("lu_after", 32'(ctl), 32'(P_RUN));
        check("lu_stall", 32'(stall_cnt), 32'd1);
        tick();

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            check("dmiss_ctl", 32'(ctl), 32'(P_FRZ));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("dmiss_after", 32'(ctl), 32'(P_RUN));
        check("dmiss_stall", 32'(stall_cnt), 32'd4);
        check("dmiss_hang", 32'(hang_err), 32'd0);
        tick();

        drive(0, 1, 0, 0, 0, 1, 0);
        check("br_imiss", 32'(ctl), 32'(P_BR));
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            check("kill_wait", 32'(ctl), 32'(P_KILL));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("kill_fall", 32'(ctl), 32'(P_KFALL));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("kill_done", 32'(ctl), 32'(P_RUN));
        check("kill_stall", 32'(stall_cnt), 32'd6);
        tick();

        drive(0, 0, 1, 0, 0, 0, 1);
        check("fw_enter", 32'(ctl), 32'(P_FRZ));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, (i == 1), 0);
            check("fw_wait", 32'(ctl), 32'(P_FRZ));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("fw_flush", 32'(ctl), 32'(P_FLUSH));
        check("fw_stall", 32'(stall_cnt), 32'd10);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("fw_done", 32'(ctl), 32'(P_RUN));
        check("fw_hang", 32'(hang_err), 32'd0);
        tick();

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0);
            check("ex_busy", 32'(ctl), 32'(P_EX));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ex_done", 32'(ctl), 32'(P_RUN));
        check("stall_sat", 32'(stall_cnt), 32'd15);
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            check("hang_rise", 32'(hang_err), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("hang_sticky", 32'(hang_err), 32'd1);
        check("stall_nowrap", 32'(stall_cnt), 32'd15);
        tick();

        drive(0, 1, 0, 0, 0, 1, 0);
        check("br_imiss2", 32'(ctl), 32'(P_BR));
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        check("rst_mid", 32'(ctl), 32'(P_RST));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_run", 32'(ctl), 32'(P_RUN));
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_hang", 32'(hang_err), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
